// File: rtl/dmem_arb_if.sv
// Bundle between the data-memory arbiter, its two requesters and the memory.
// slave = arbiter side, master = requesters plus memory side.
interface dmem_arb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              err0;
  logic              err1;
  logic              busy;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1,
    output rdata0, rdata1, err0, err1, busy,
    output mem_we, mem_re, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1,
    input  rdata0, rdata1, err0, err1, busy,
    input  mem_we, mem_re, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one data memory between port 0
// (CPU) and port 1 (DMA). Ports: clk, rst (async active-low), bus (slave).
// Optional DMEM_ARB_PERF_CNT_EN adds gnt_cnt0/gnt_cnt1/conflict_cnt.
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  dmem_arb_if.slave   bus
`ifdef DMEM_ARB_PERF_CNT_EN
  ,
  output logic [15:0] gnt_cnt0,
  output logic [15:0] gnt_cnt1,
  output logic [15:0] conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RD_WAIT,
    ERR
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L =
    (ADDR_W+1)'(DEPTH);
  localparam logic [2:0] LAST_CNT =
    3'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              err0_q, err0_d;
  logic              err1_q, err1_d;
  logic              mwe_q, mwe_d;
  logic              mre_q, mre_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;
  logic              pend0_q, pend0_d;
  logic              pend1_q, pend1_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;

  logic              sel_v;
  logic              sel_p;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_oor;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    port_d   = port_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    mwe_d    = 1'b0;
    mre_d    = 1'b0;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    pend0_d  = 1'b0;
    pend1_d  = 1'b0;
    cap_d    = cap_q;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    sel_v    = 1'b0;
    sel_p    = 1'b0;
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_wdata = '0;
    sel_oor  = 1'b0;

    // Captured load data is presented one cycle after the capture
    // edge, so it may overlap the next access's gnt.
    rv0_d = pend0_q;
    rv1_d = pend1_q;
    if (pend0_q) rd0_d = cap_q;
    if (pend1_q) rd1_d = cap_q;

    unique case (state_q)
      IDLE: begin
        sel_v = bus.req0 | bus.req1;
        unique case (1'b1)
          bus.req0 && bus.req1: sel_p = ~last_q;
          !bus.req0 && bus.req1: sel_p = 1'b1;
          default:               sel_p = 1'b0;
        endcase
        sel_we    = sel_p ? bus.we1    : bus.we0;
        sel_addr  = sel_p ? bus.addr1  : bus.addr0;
        sel_wdata = sel_p ? bus.wdata1 : bus.wdata0;
        sel_oor   = {1'b0, sel_addr} >= DEPTH_L;
        if (sel_v) begin
          last_d = sel_p;
          port_d = sel_p;
          we_d   = sel_we;
          gnt0_d = ~sel_p;
          gnt1_d = sel_p;
          if (sel_oor) begin
            // ERR covers the gnt cycle so the still-held
            // req is not sampled a second time.
            err0_d  = ~sel_p;
            err1_d  = sel_p;
            state_d = ERR;
          end else begin
            maddr_d  = sel_addr;
            mwdata_d = sel_wdata;
            mwe_d    = sel_we;
            mre_d    = ~sel_we;
            state_d  = ACCESS;
          end
        end
      end
      ACCESS: begin
        cnt_d   = '0;
        state_d = we_q ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          cap_d   = bus.mem_rdata;
          pend0_d = ~port_q;
          pend1_d = port_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      mwe_q    <= 1'b0;
      mre_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      pend0_q  <= 1'b0;
      pend1_q  <= 1'b0;
      cap_q    <= '0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      port_q   <= port_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      mwe_q    <= mwe_d;
      mre_q    <= mre_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      pend0_q  <= pend0_d;
      pend1_q  <= pend1_d;
      cap_q    <= cap_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.rvalid0   = rv0_q;
  assign bus.rvalid1   = rv1_q;
  assign bus.rdata0    = rd0_q;
  assign bus.rdata1    = rd1_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.mem_we    = mwe_q;
  assign bus.mem_re    = mre_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;

`ifdef DMEM_ARB_PERF_CNT_EN
  logic [15:0] gc0_q;
  logic [15:0] gc1_q;
  logic [15:0] cf_q;
  logic        cf_hit;

  assign cf_hit = (state_q == IDLE)
                & bus.req0 & bus.req1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gc0_q <= '0;
      gc1_q <= '0;
      cf_q  <= '0;
    end else begin
      if (sel_v && !sel_p && gc0_q != 16'hFFFF)
        gc0_q <= gc0_q + 16'd1;
      if (sel_v && sel_p && gc1_q != 16'hFFFF)
        gc1_q <= gc1_q + 16'd1;
      if (cf_hit && cf_q != 16'hFFFF)
        cf_q <= cf_q + 16'd1;
    end
  end

  assign gnt_cnt0     = gc0_q;
  assign gnt_cnt1     = gc1_q;
  assign conflict_cnt = cf_q;
`else
  // Counters are absent in this build.
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table of single accesses
// plus round-robin, reset-abort and counter sequences.
module tb_dmem_arbiter;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int DEP = 32;
  localparam int RDL = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

`ifdef DMEM_ARB_PERF_CNT_EN
  logic [15:0] gnt_cnt0;
  logic [15:0] gnt_cnt1;
  logic [15:0] conflict_cnt;
`endif

  dmem_arbiter #(
    .DATA_W(DW), .ADDR_W(AW),
    .DEPTH(DEP), .RD_LAT(RDL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DMEM_ARB_PERF_CNT_EN
    ,
    .gnt_cnt0(gnt_cnt0),
    .gnt_cnt1(gnt_cnt1),
    .conflict_cnt(conflict_cnt)
`endif
  );

  // Memory model: one-cycle registered read, unwritten word i reads i+1.
  logic [31:0] mem [32];
  bit          wr_ok [32];
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr[4:0]]   <= bus.mem_wdata;
      wr_ok[bus.mem_addr[4:0]] <= 1'b1;
    end
    if (bus.mem_re)
      bus.mem_rdata <= wr_ok[bus.mem_addr[4:0]]
        ? mem[bus.mem_addr[4:0]]
        : 32'(bus.mem_addr[4:0]) + 32'd1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [10];

  task automatic idle_inputs();
    bus.req0 = 0; bus.req1 = 0;
    bus.we0 = 0;  bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0;
    bus.wdata0 = 0; bus.wdata1 = 0;
  endtask

  task automatic run_vec(input string tg,
                         input vec_t v);
    int  lat;
    bit  got;
    bit  other;
    logic [31:0] rd;
    if (v.port) begin
      bus.req1 = 1; bus.we1 = v.we;
      bus.addr1 = v.addr; bus.wdata1 = v.wdata;
    end else begin
      bus.req0 = 1; bus.we0 = v.we;
      bus.addr0 = v.addr; bus.wdata0 = v.wdata;
    end
    @(negedge clk);
    chk({tg, "_gnt0"}, 32'(bus.gnt0), 32'(!v.port));
    chk({tg, "_gnt1"}, 32'(bus.gnt1), 32'(v.port));
    chk({tg, "_err0"}, 32'(bus.err0),
        32'(!v.port && v.err));
    chk({tg, "_err1"}, 32'(bus.err1),
        32'(v.port && v.err));
    chk({tg, "_mwe"}, 32'(bus.mem_we),
        32'(v.we && !v.err));
    chk({tg, "_mre"}, 32'(bus.mem_re),
        32'(!v.we && !v.err));
    chk({tg, "_busy1"}, 32'(bus.busy), 32'd1);
    if (!v.err) chk({tg, "_maddr"}, bus.mem_addr, v.addr);
    if (!v.err && v.we)
      chk({tg, "_mwdata"}, bus.mem_wdata, v.wdata);
    idle_inputs();
    if (v.we || v.err) begin
      @(negedge clk);
      chk({tg, "_busy0"}, 32'(bus.busy), 32'd0);
      chk({tg, "_mwe_off"}, 32'(bus.mem_we), 32'd0);
    end else begin
      lat = 0; got = 0; other = 0; rd = '0;
      while (!got && lat < 10) begin
        @(negedge clk);
        lat++;
        if (v.port) begin
          got = bus.rvalid1; rd = bus.rdata1;
          other = other | bus.rvalid0;
        end else begin
          got = bus.rvalid0; rd = bus.rdata0;
          other = other | bus.rvalid1;
        end
      end
      chk({tg, "_lat"}, lat, RDL + 2);
      chk({tg, "_rdata"}, rd, v.rdata);
      chk({tg, "_rv_other"}, 32'(other), 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tg);
    chk({tg, "_gnt"}, {bus.gnt0, bus.gnt1}, 0);
    chk({tg, "_rv"}, {bus.rvalid0, bus.rvalid1}, 0);
    chk({tg, "_err"}, {bus.err0, bus.err1}, 0);
    chk({tg, "_busy"}, 32'(bus.busy), 0);
    chk({tg, "_men"}, {bus.mem_we, bus.mem_re}, 0);
    chk({tg, "_maddr"}, bus.mem_addr, 0);
    chk({tg, "_mwd"}, bus.mem_wdata, 0);
    chk({tg, "_rd0"}, bus.rdata0, 0);
    chk({tg, "_rd1"}, bus.rdata1, 0);
  endtask

  // Holds both ports on loads until n grants; returns the grant order.
  task automatic contend(input int n, output int ord [4],
                         output int nrv);
    int ng;
    int cyc;
    ng = 0; nrv = 0; cyc = 0;
    for (int k = 0; k < 4; k++) ord[k] = -1;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 7;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 9;
    while (cyc < 40 && (ng < n || nrv < n)) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt0 && bus.gnt1)
        chk("rr_both_gnt", 1, 0);
      if (bus.gnt0 || bus.gnt1) begin
        if (ng < 4) ord[ng] = bus.gnt1 ? 1 : 0;
        ng++;
        if (ng == n) idle_inputs();
      end
      if (bus.rvalid0) begin
        nrv++; chk("rr_rd0", bus.rdata0, 32'd8);
      end
      if (bus.rvalid1) begin
        nrv++; chk("rr_rd1", bus.rdata1, 32'd10);
      end
    end
    idle_inputs();
  endtask

  int ord [4];
  int nrv;
  bit seen;

  initial begin
    vt[0] = '{0, 1, 3,  32'h20,       0, 0};
    vt[1] = '{1, 0, 5,  0,            0, 32'h6};
    vt[2] = '{0, 0, 3,  0,            0, 32'h20};
    vt[3] = '{1, 1, 31, 32'hDEADBEEF, 0, 0};
    vt[4] = '{0, 0, 31, 0,            0, 32'hDEADBEEF};
    vt[5] = '{0, 1, 32, 32'h55,       1, 0};
    vt[6] = '{1, 0, 40, 0,            1, 0};
    vt[7] = '{1, 0, 0,  0,            0, 32'h1};
    vt[8] = '{1, 1, 0,  32'h77,       0, 0};
    vt[9] = '{0, 0, 0,  0,            0, 32'h77};

    idle_inputs();
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_vec($sformatf("v%0d", i), vt[i]);

    // Round robin after a fresh reset: 0,1,0,1.
    rst = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    contend(4, ord, nrv);
    chk("rr_g0", ord[0], 0);
    chk("rr_g1", ord[1], 1);
    chk("rr_g2", ord[2], 0);
    chk("rr_g3", ord[3], 1);
    chk("rr_nrv", nrv, 4);

    // Reset in RD_WAIT of a port-1 load.
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 5;
    @(negedge clk);
    chk("ab_gnt1", 32'(bus.gnt1), 1);
    idle_inputs();
    @(negedge clk);
    chk("ab_busy", 32'(bus.busy), 1);
    rst = 0;
    #1;
    chk_all_zero("ab");
    repeat (2) @(negedge clk);
    rst = 1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | bus.rvalid1;
    end
    chk("ab_no_rv1", 32'(seen), 0);

    // Three contended samples then two lone port-0 stores.
    contend(3, ord, nrv);
    chk("pc_g0", ord[0], 0);
    chk("pc_g1", ord[1], 1);
    chk("pc_g2", ord[2], 0);
    run_vec("pc_s0", '{0, 1, 10, 32'hA, 0, 0});
    run_vec("pc_s1", '{0, 1, 11, 32'hB, 0, 0});
`ifdef DMEM_ARB_PERF_CNT_EN
    chk("pc_conf", 32'(conflict_cnt), 3);
    chk("pc_gc0", 32'(gnt_cnt0), 4);
    chk("pc_gc1", 32'(gnt_cnt1), 1);
`endif
    run_vec("pc_l0", '{1, 0, 11, 0, 0, 32'hB});

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
